// File: rtl/cmp20_e.sv
// 20-bit equality comparator: comb a_eql_b/nib_eq (0 cycles), a_eql_b_q 1 cycle, no backpressure.
// Optional compare-ignore mask input under CMP20_E_MASK_EN.
module cmp20_e (
   input  logic        clk,
   input  logic        reset_l,
   input  logic [19:0] ai,
   input  logic [19:0] bi,
   input  logic        en,
`ifdef CMP20_E_MASK_EN
   input  logic [19:0] mask,
`endif
   output logic        a_eql_b,
   output logic [4:0]  nib_eq,
   output logic        a_eql_b_q
);

   logic [19:0] w_eq;
   logic        r_a_eql_b_q;

   // XNOR keeps X on unknown operand bits; a masked bit is forced to match.
`ifdef CMP20_E_MASK_EN
   assign w_eq = ~(ai ^ bi) | mask;
`else
   assign w_eq = ~(ai ^ bi);
`endif

   always_comb begin
      nib_eq = 5'b00000;
      for (int k = 0; k < 5; k++) begin
         nib_eq[k] = &w_eq[4*k +: 4];
      end
   end

   assign a_eql_b = &nib_eq;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_a_eql_b_q <= 1'b0;
      end else if (en) begin
         r_a_eql_b_q <= a_eql_b;
      end
   end

   assign a_eql_b_q = r_a_eql_b_q;

endmodule

// File: tb/tb_cmp20_e.sv
// Directed bench for cmp20_e; mask cases run only when CMP20_E_MASK_EN is defined.
module tb_cmp20_e;

   logic        clk;
   logic        reset_l;
   logic [19:0] ai;
   logic [19:0] bi;
   logic        en;
   logic [19:0] mask;
   logic        a_eql_b;
   logic [4:0]  nib_eq;
   logic        a_eql_b_q;

   int checks;
   int failures;

   cmp20_e dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .ai        (ai),
      .bi        (bi),
      .en        (en),
`ifdef CMP20_E_MASK_EN
      .mask      (mask),
`endif
      .a_eql_b   (a_eql_b),
      .nib_eq    (nib_eq),
      .a_eql_b_q (a_eql_b_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_l  = 1'b0;
      en       = 1'b0;
      mask     = 20'h00000;
      ai       = 20'h00000;
      bi       = 20'h00001;
      #1;
      chk("reset_q", {19'd0, a_eql_b_q}, 20'd0);
      chk("reset_comb_eq", {19'd0, a_eql_b}, 20'd0);
      chk("reset_comb_nib", {15'd0, nib_eq}, 20'h1E);

      // Comparator works and capture is blocked while reset is held
      @(negedge clk);
      ai = 20'h00000; bi = 20'h00000; en = 1'b1;
      #1;
      chk("zero_eq_in_reset", {19'd0, a_eql_b}, 20'd1);
      @(posedge clk); #1;
      chk("q_held_in_reset", {19'd0, a_eql_b_q}, 20'd0);

      @(negedge clk);
      reset_l = 1'b1;
      ai = 20'h5A3C1; bi = 20'h5A3C1; en = 1'b1;
      #1;
      chk("eq_5A3C1", {19'd0, a_eql_b}, 20'd1);
      chk("nib_5A3C1", {15'd0, nib_eq}, 20'h1F);
      chk("q_before_edge", {19'd0, a_eql_b_q}, 20'd0);
      @(posedge clk); #1;
      chk("q_after_edge", {19'd0, a_eql_b_q}, 20'd1);

      @(negedge clk);
      ai = 20'hDA3C1; bi = 20'h5A3C1;
      #1;
      chk("msb_diff_eq", {19'd0, a_eql_b}, 20'd0);
      chk("msb_diff_nib", {15'd0, nib_eq}, 20'h0F);
      @(posedge clk); #1;
      chk("q_loads_zero", {19'd0, a_eql_b_q}, 20'd0);

      @(negedge clk);
      ai = 20'h5A3C0; bi = 20'h5A3C1;
      #1;
      chk("lsb_diff_eq", {19'd0, a_eql_b}, 20'd0);
      chk("lsb_diff_nib", {15'd0, nib_eq}, 20'h1E);

      ai = 20'hFFFFF; bi = 20'hFFFFF;
      #1;
      chk("ones_eq", {19'd0, a_eql_b}, 20'd1);

      ai = 20'h80000; bi = 20'h00000;
      #1;
      chk("bit19_only_eq", {19'd0, a_eql_b}, 20'd0);
      chk("bit19_only_nib", {15'd0, nib_eq}, 20'h0F);

      ai = 20'h00010; bi = 20'h00000;
      #1;
      chk("bit4_only_nib", {15'd0, nib_eq}, 20'h1D);

      // Tag-hit style compare: {unused, valid, tag}
      ai = 20'h6ABCD; bi = 20'h6ABCD;
      #1;
      chk("tag_hit", {19'd0, a_eql_b}, 20'd1);
      ai = 20'h2ABCD;
      #1;
      chk("tag_invalid", {19'd0, a_eql_b}, 20'd0);
      chk("tag_invalid_nib", {15'd0, nib_eq}, 20'h0F);

      // Hold with en=0
      ai = 20'h12345; bi = 20'h12345; en = 1'b1;
      @(posedge clk); #1;
      chk("q_set_again", {19'd0, a_eql_b_q}, 20'd1);
      @(negedge clk);
      en = 1'b0; ai = 20'h12345; bi = 20'h12344;
      @(posedge clk); #1;
      chk("q_hold_en0", {19'd0, a_eql_b_q}, 20'd1);

      // Asynchronous reset pulse between edges
      @(negedge clk);
      ai = 20'hABCDE; bi = 20'hABCDE;
      #1;
      reset_l = 1'b0;
      #1;
      chk("q_async_clear", {19'd0, a_eql_b_q}, 20'd0);
      chk("comb_during_pulse", {19'd0, a_eql_b}, 20'd1);
      #1;
      reset_l = 1'b1;
      @(posedge clk); #1;
      chk("q_stays0_en0", {19'd0, a_eql_b_q}, 20'd0);
      @(negedge clk);
      en = 1'b1;
      @(posedge clk); #1;
      chk("q_resume_en1", {19'd0, a_eql_b_q}, 20'd1);

`ifdef CMP20_E_MASK_EN
      @(negedge clk);
      ai = 20'h00F00; bi = 20'h00000; mask = 20'h00F00;
      #1;
      chk("mask_full_nib", {19'd0, a_eql_b}, 20'd1);
      mask = 20'h00700;
      #1;
      chk("mask_partial_eq", {19'd0, a_eql_b}, 20'd0);
      chk("mask_partial_nib", {15'd0, nib_eq}, 20'h1B);
      ai = 20'h12345; bi = 20'hEDCBA; mask = 20'hFFFFF;
      #1;
      chk("mask_all_eq", {19'd0, a_eql_b}, 20'd1);
      chk("mask_all_nib", {15'd0, nib_eq}, 20'h1F);
      mask = 20'h00000;
      #1;
      chk("mask_zero_eq", {19'd0, a_eql_b}, 20'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmp20_e.md
CMP20_E -- requirements
Module: cmp20_e

Interface
REQ-001 Parameters: none; compare width fixed at 20 bits, bit 19 MSB.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_l  input  1  asynchronous, active-low reset.
REQ-004 ai  input  20  operand A.
REQ-005 bi  input  20  operand B.
REQ-006 en  input  1  registered-output update enable, active high.
REQ-007 a_eql_b  output  1  combinational: 1 when all compared bits of ai and bi match.
REQ-008 nib_eq  output  5  combinational per-nibble equality; nib_eq[k] covers bits [4k+3:4k].
REQ-009 a_eql_b_q  output  1  registered copy of a_eql_b.
REQ-010 mask  input  20  compare-ignore bits; present only with CMP20_E_MASK_EN defined.

Function
REQ-011 a_eql_b SHALL be purely combinational from ai, bi (and mask), with zero-cycle latency and no dependence on clk, reset_l or en.
REQ-012 Bitwise equality: eq[i] = ~(ai[i] ^ bi[i]), forced to 1 where masked.
REQ-013 nib_eq[k] SHALL be the AND of eq[4k+3:4k] for k = 0..4.
REQ-014 a_eql_b SHALL be the AND of nib_eq[4:0], i.e. 1 only when every compared bit matches.
REQ-015 On a rising clk edge with en=1, a_eql_b_q SHALL load a_eql_b; with en=0 it SHALL hold its value.
REQ-016 Latency of a_eql_b_q relative to ai/bi: one clock edge.
REQ-017 Boundaries: ai=bi=20'h00000 gives 1; ai=bi=20'hFFFFF gives 1; any single-bit difference, including bit 19 or bit 0, gives 0.
REQ-018 Operands SHALL be treated as unsigned bit vectors; there is no sign or magnitude interpretation.
REQ-019 An X or Z on any compared bit SHALL propagate X to the affected nib_eq bit and to a_eql_b in simulation. This is not masked to 0.

Reset
REQ-020 While reset_l=0, a_eql_b_q SHALL be 0 immediately, independent of clk.
REQ-021 Reset SHALL NOT affect the combinational outputs a_eql_b and nib_eq.
REQ-022 After reset_l deasserts, a_eql_b_q SHALL resume loading on the first rising clk edge with en=1.
REQ-023 Reset asserted mid-operation SHALL override en and any pending capture.

Configuration
REQ-024 Macro CMP20_E_MASK_EN, when defined, SHALL add the mask input. A bit i with mask[i]=1 is excluded from comparison; all-ones mask yields a_eql_b=1 and nib_eq=5'b11111.
REQ-025 Without CMP20_E_MASK_EN, there SHALL be no mask port and all 20 bits SHALL be compared.
REQ-026 Both configurations SHALL give identical results when mask=20'h00000.

Verification
REQ-027 Equal operands: ai=bi=20'h5A3C1, en=1 -> a_eql_b=1, nib_eq=5'b11111 immediately; a_eql_b_q=1 after the next clk edge.
REQ-028 MSB difference: ai=20'hDA3C1, bi=20'h5A3C1 -> a_eql_b=0, nib_eq=5'b01111; LSB difference: ai=20'h5A3C0, bi=20'h5A3C1 -> nib_eq=5'b11110.
REQ-029 Tag-hit use: ai={1'b0,1'b1,18'h2ABCD}, bi={2'b01,18'h2ABCD} -> 1; ai valid bit cleared (ai[18]=0) -> 0.
REQ-030 Hold and reset: a_eql_b_q=1, en=0, operands changed to unequal -> a_eql_b_q stays 1; reset_l pulsed low between edges -> a_eql_b_q=0 at once, stays 0 until an edge with en=1.
REQ-031 Mask (CMP20_E_MASK_EN defined): ai=20'h00F00, bi=20'h00000, mask=20'h00F00 -> a_eql_b=1; mask=20'h00700 -> a_eql_b=0, nib_eq=5'b11011.
